// File: rtl/rv32im_pkg.sv
// Shared definitions for the rv32im front end: fetch FSM encoding and bus/instruction constants.
package rv32im_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUS  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [3:0]  SEL_WORD  = 4'b1111;

endpackage

// File: rtl/rv32im_fetch_fifo.sv
// Synchronous FIFO of {pc, instruction} pairs with flush; head is presented combinationally.
module rv32im_fetch_fifo
  import rv32im_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    push_data_i,
  input  logic                pop_i,
  output logic [PTR_BITS:0]   count_o,
  output logic                valid_o,
  output logic [WIDTH-1:0]    head_o
);

  localparam int CNT_W = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_r;
  logic [PTR_BITS-1:0] rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                full_s;
  logic                do_push_s;
  logic                do_pop_s;

  assign valid_o   = (count_r != {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop_i & valid_o;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push_s = push_i & (~full_s | do_pop_s);
  assign count_o   = count_r;
  assign head_o    = valid_o ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

  // Storage, pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(INSTR_NOP);
      end
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_BITS'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!do_push_s && do_pop_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv32im_fetch_queue.sv
// Instruction fetch front end: Wishbone burst fetcher with redirect/discard handling,
// feeding a small {pc, instruction} buffer that decode pops one entry per cycle.
module rv32im_fetch_queue
  import rv32im_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_BITS  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            pc_write_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            advance_i,
  output logic            data_ready_o,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_err_o,
  output logic [XLEN-1:0] err_pc_o,
  output logic            ctrl_req_o,
  input  logic            ctrl_grant_i,
  input  logic [XLEN-1:0] master_dat_i,
  input  logic            ack_i,
  input  logic            err_i,
  output logic [XLEN-3:0] adr_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [3:0]      sel_o
);

  localparam int CNT_W      = PTR_BITS + 1;
  localparam int BURST_BITS = $clog2(MAX_BURST + 1);

  fetch_state_e          state_r;
  fetch_state_e          state_s;
  logic [XLEN-1:0]       fetch_pc_r;
  logic [XLEN-1:0]       fetch_pc_s;
  logic [XLEN-3:0]       adr_r;
  logic                  discard_r;
  logic                  discard_s;
  logic [BURST_BITS-1:0] burst_cnt_r;
  logic [BURST_BITS-1:0] burst_cnt_s;
  logic [BURST_BITS-1:0] burst_inc_s;
  logic                  ctrl_req_r;
  logic                  bus_r;
  logic                  fetch_err_r;
  logic [XLEN-1:0]       err_pc_r;

  logic [CNT_W-1:0]      count_s;
  logic [CNT_W-1:0]      count_after_s;
  logic [CNT_W-1:0]      room_s;
  logic [CNT_W-1:0]      room_after_s;
  logic                  fifo_valid_s;
  logic [2*XLEN-1:0]     head_s;
  logic                  in_bus_s;
  logic                  bus_done_s;
  logic                  accept_s;
  logic                  err_hit_s;
  logic                  pop_eff_s;
  logic                  burst_more_s;

  rv32im_fetch_fifo #(
    .WIDTH    (2 * XLEN),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .flush_i     (pc_write_i),
    .push_i      (accept_s),
    .push_data_i ({adr_r, 2'b00, master_dat_i}),
    .pop_i       (advance_i),
    .count_o     (count_s),
    .valid_o     (fifo_valid_s),
    .head_o      (head_s)
  );

  assign in_bus_s   = (state_r == ST_BUS);
  assign bus_done_s = in_bus_s & (ack_i | err_i);
  // Responses arriving during a pending redirect, or alongside one, are never kept.
  assign accept_s   = in_bus_s & ack_i & ~err_i & ~discard_r & ~pc_write_i;
  assign err_hit_s  = in_bus_s & err_i & ~discard_r & ~pc_write_i;
  assign pop_eff_s  = advance_i & fifo_valid_s;

  assign room_s       = CNT_W'(DEPTH) - count_s - CNT_W'(in_bus_s);
  assign room_after_s = CNT_W'(DEPTH) - count_after_s;
  assign burst_inc_s  = burst_cnt_r + BURST_BITS'(1);
  assign burst_more_s = (room_after_s != {CNT_W{1'b0}}) && (burst_inc_s < BURST_BITS'(MAX_BURST));

  // Occupancy once this cycle's push and pop have both taken effect.
  always_comb begin
    count_after_s = count_s;
    if (accept_s && !pop_eff_s) begin
      count_after_s = count_s + CNT_W'(1);
    end else if (!accept_s && pop_eff_s) begin
      count_after_s = count_s - CNT_W'(1);
    end else begin
      count_after_s = count_s;
    end
  end

  // Fetch FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!pc_write_i && (room_s != {CNT_W{1'b0}})) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (pc_write_i) begin
          state_s = ST_IDLE;
        end else if (ctrl_grant_i) begin
          state_s = ST_BUS;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_BUS: begin
        if (bus_done_s) begin
          if (discard_r || pc_write_i) begin
            state_s = ST_IDLE;
          end else if (err_i) begin
            state_s = ST_HALT;
          end else if (burst_more_s) begin
            state_s = ST_BUS;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_BUS;
        end
      end
      ST_HALT: begin
        if (pc_write_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Fetch pointer, discard flag and burst length bookkeeping.
  always_comb begin
    fetch_pc_s  = fetch_pc_r;
    discard_s   = discard_r;
    burst_cnt_s = burst_cnt_r;

    if (pc_write_i) begin
      fetch_pc_s = pc_i & ~XLEN'(3);
    end else if (accept_s) begin
      fetch_pc_s = fetch_pc_r + XLEN'(4);
    end else begin
      fetch_pc_s = fetch_pc_r;
    end

    // An outstanding bus cycle cannot be abandoned, so a redirect marks its response for dropping.
    if (!in_bus_s || bus_done_s) begin
      discard_s = 1'b0;
    end else if (pc_write_i) begin
      discard_s = 1'b1;
    end else begin
      discard_s = discard_r;
    end

    if (pc_write_i || (state_s != ST_BUS)) begin
      burst_cnt_s = {BURST_BITS{1'b0}};
    end else if (accept_s) begin
      burst_cnt_s = burst_inc_s;
    end else begin
      burst_cnt_s = burst_cnt_r;
    end
  end

  // State and registered bus/error outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r     <= ST_IDLE;
      fetch_pc_r  <= {XLEN{1'b0}};
      adr_r       <= {(XLEN-2){1'b0}};
      discard_r   <= 1'b0;
      burst_cnt_r <= {BURST_BITS{1'b0}};
      ctrl_req_r  <= 1'b0;
      bus_r       <= 1'b0;
      fetch_err_r <= 1'b0;
      err_pc_r    <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      discard_r   <= discard_s;
      burst_cnt_r <= burst_cnt_s;
      ctrl_req_r  <= (state_s == ST_REQ) || (state_s == ST_BUS);
      bus_r       <= (state_s == ST_BUS);
      fetch_err_r <= err_hit_s;
      // The address stays frozen while a bus cycle waits for its response.
      if (!(in_bus_s && !bus_done_s)) begin
        adr_r <= fetch_pc_s[XLEN-1:2];
      end
      if (err_hit_s) begin
        err_pc_r <= {adr_r, 2'b00};
      end
    end
  end

  assign data_ready_o  = fifo_valid_s;
  assign instruction_o = head_s[XLEN-1:0];
  assign pc_o          = head_s[2*XLEN-1:XLEN];
  assign fetch_err_o   = fetch_err_r;
  assign err_pc_o      = err_pc_r;
  assign ctrl_req_o    = ctrl_req_r;
  assign adr_o         = adr_r;
  assign cyc_o         = bus_r;
  assign stb_o         = bus_r;
  assign sel_o         = SEL_WORD;

endmodule

// File: tb/tb_rv32im_fetch_queue.sv
// Directed self-checking bench for rv32im_fetch_queue with a zero-wait or hand-driven bus responder.
module tb_rv32im_fetch_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        pc_write_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        advance_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;
  logic [31:0] err_pc_o;
  logic        ctrl_req_o;
  logic        ctrl_grant_i;
  logic [31:0] master_dat_i;
  logic        ack_i;
  logic        err_i;
  logic [29:0] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic [3:0]  sel_o;

  logic        auto_mode = 1'b1;
  logic        grant_en = 1'b1;
  logic        ack_man = 1'b0;
  logic        err_man = 1'b0;
  logic [31:0] dat_man = 32'h0;

  int n_total = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  // Memory returns 0xC0DE in the upper half and the low byte address in the lower half.
  assign ctrl_grant_i = grant_en & ctrl_req_o;
  assign ack_i        = auto_mode ? stb_o : ack_man;
  assign err_i        = err_man;
  assign master_dat_i = auto_mode ? {16'hC0DE, adr_o[13:0], 2'b00} : dat_man;

  rv32im_fetch_queue dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .pc_write_i    (pc_write_i),
    .pc_i          (pc_i),
    .advance_i     (advance_i),
    .data_ready_o  (data_ready_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .fetch_err_o   (fetch_err_o),
    .err_pc_o      (err_pc_o),
    .ctrl_req_o    (ctrl_req_o),
    .ctrl_grant_i  (ctrl_grant_i),
    .master_dat_i  (master_dat_i),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .adr_o         (adr_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .sel_o         (sel_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    pc_write_i = 1'b1;
    pc_i = a;
    step();
    pc_write_i = 1'b0;
  endtask

  task automatic wait_stb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (stb_o) seen = 1'b1;
      else step();
    end
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (data_ready_o) seen = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    step();
    step();
    n_total++;
    if ({data_ready_o, ctrl_req_o, cyc_o, stb_o, fetch_err_o} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000", {data_ready_o, ctrl_req_o, cyc_o, stb_o, fetch_err_o});
    else n_pass++;
    n_total++;
    if ({adr_o, err_pc_o, pc_o, instruction_o} !== 126'h0)
      $display("FAIL reset_data adr=%h err_pc=%h pc=%h ins=%h want all 0", adr_o, err_pc_o, pc_o, instruction_o);
    else n_pass++;
    n_total++;
    if (sel_o !== 4'b1111) $display("FAIL reset_sel got=%b want=1111", sel_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    int acks;
    reset_ni = 1'b1;
    redirect(32'h0000_0100);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (stb_o && ack_i) acks++;
    end
    n_total++;
    if (acks !== 4) $display("FAIL fill_acks got=%0d want=4", acks);
    else n_pass++;
    n_total++;
    if ({ctrl_req_o, data_ready_o} !== 2'b01) $display("FAIL fill_req_ready got=%b want=01", {ctrl_req_o, data_ready_o});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pc_o !== 32'h100 + 32'(4 * i) || instruction_o !== (32'hC0DE_0100 + 32'(4 * i)))
        $display("FAIL fill_head%0d pc=%h ins=%h want pc=%h", i, pc_o, instruction_o, 32'h100 + 32'(4 * i));
      else n_pass++;
      advance_i = 1'b1;
      step();
      advance_i = 1'b0;
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int pops, low, run;
    bit seen_req;
    advance_i = 1'b1;
    redirect(32'h0000_0100);
    exp_pc = 32'h100;
    pops = 0; low = 0; run = 0; seen_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (data_ready_o) begin
        n_total++;
        if (pc_o !== exp_pc || instruction_o !== {16'hC0DE, exp_pc[15:0]})
          $display("FAIL stream_pc got=%h ins=%h want=%h", pc_o, instruction_o, exp_pc);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (ctrl_req_o) begin
        if (seen_req && low != 0) begin
          n_total++;
          if (low !== 1) $display("FAIL stream_req_gap got=%0d want=1", low);
          else n_pass++;
        end
        seen_req = 1'b1;
        low = 0;
      end else if (seen_req) begin
        low++;
      end
      if (stb_o) run++;
      else begin
        if (run != 0) begin
          n_total++;
          if (run !== 4) $display("FAIL stream_burst_len got=%0d want=4", run);
          else n_pass++;
        end
        run = 0;
      end
    end
    n_total++;
    if (pops !== 26) $display("FAIL stream_words got=%0d want=26", pops);
    else n_pass++;
    advance_i = 1'b0;
    grant_en = 1'b0;
    redirect(32'h0);
  endtask

  task automatic test_discard();
    bit seen, got, bad;
    logic [31:0] first_pc, first_ins;
    grant_en = 1'b1;
    redirect(32'h0000_0500);
    auto_mode = 1'b0;
    ack_man = 1'b0;
    wait_stb(seen);
    n_total++;
    if (!seen || adr_o !== 30'h140) $display("FAIL discard_start stb=%b adr=%h want 1 140", stb_o, adr_o);
    else n_pass++;
    pc_write_i = 1'b1;
    pc_i = 32'h0000_2000;
    step();
    pc_write_i = 1'b0;
    n_total++;
    if ({stb_o, adr_o, data_ready_o} !== {1'b1, 30'h140, 1'b0})
      $display("FAIL discard_hold stb=%b adr=%h rdy=%b want 1 140 0", stb_o, adr_o, data_ready_o);
    else n_pass++;
    step();
    ack_man = 1'b1;
    dat_man = 32'hDEAD_BEEF;
    step();
    ack_man = 1'b0;
    auto_mode = 1'b1;
    n_total++;
    if ({stb_o, data_ready_o} !== 2'b00) $display("FAIL discard_drop stb=%b rdy=%b want 00", stb_o, data_ready_o);
    else n_pass++;
    got = 1'b0; bad = 1'b0; first_pc = 32'h0; first_ins = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (data_ready_o && instruction_o == 32'hDEAD_BEEF) bad = 1'b1;
      if (data_ready_o && !got) begin
        got = 1'b1;
        first_pc = pc_o;
        first_ins = instruction_o;
      end
    end
    n_total++;
    if (!got || bad || first_pc !== 32'h2000 || first_ins !== 32'hC0DE_2000)
      $display("FAIL discard_first got=%b bad=%b pc=%h ins=%h want 1 0 2000 c0de2000", got, bad, first_pc, first_ins);
    else n_pass++;
  endtask

  task automatic test_ack_redirect();
    bit seen;
    redirect(32'h0000_0600);
    auto_mode = 1'b0;
    ack_man = 1'b0;
    wait_stb(seen);
    n_total++;
    if (!seen || adr_o !== 30'h180) $display("FAIL ackred_start stb=%b adr=%h want 1 180", stb_o, adr_o);
    else n_pass++;
    ack_man = 1'b1;
    dat_man = 32'h1234_5678;
    step();
    ack_man = 1'b0;
    n_total++;
    if ({data_ready_o, stb_o, adr_o, pc_o, instruction_o} !== {1'b1, 1'b1, 30'h181, 32'h600, 32'h1234_5678})
      $display("FAIL ackred_first rdy=%b stb=%b adr=%h pc=%h ins=%h want 1 1 181 600 12345678",
               data_ready_o, stb_o, adr_o, pc_o, instruction_o);
    else n_pass++;
    ack_man = 1'b1;
    dat_man = 32'h1111_1111;
    pc_write_i = 1'b1;
    pc_i = 32'h0000_0043;
    step();
    ack_man = 1'b0;
    pc_write_i = 1'b0;
    n_total++;
    if ({data_ready_o, stb_o, adr_o} !== {1'b0, 1'b0, 30'h10})
      $display("FAIL ackred_flush rdy=%b stb=%b adr=%h want 0 0 10", data_ready_o, stb_o, adr_o);
    else n_pass++;
    auto_mode = 1'b1;
    wait_ready(seen);
    n_total++;
    if (!seen || pc_o !== 32'h40 || instruction_o !== 32'hC0DE_0040)
      $display("FAIL ackred_resume rdy=%b pc=%h ins=%h want 1 40 c0de0040", seen, pc_o, instruction_o);
    else n_pass++;
  endtask

  task automatic test_bus_error();
    bit seen;
    int req_hi;
    redirect(32'h0000_0300);
    auto_mode = 1'b0;
    wait_stb(seen);
    err_man = 1'b1;
    step();
    err_man = 1'b0;
    n_total++;
    if (!seen || {fetch_err_o, ctrl_req_o, stb_o} !== 3'b100 || err_pc_o !== 32'h300)
      $display("FAIL err_pulse err=%b req=%b stb=%b err_pc=%h want 1 0 0 300", fetch_err_o, ctrl_req_o, stb_o, err_pc_o);
    else n_pass++;
    step();
    n_total++;
    if (fetch_err_o !== 1'b0 || err_pc_o !== 32'h300)
      $display("FAIL err_hold err=%b err_pc=%h want 0 300", fetch_err_o, err_pc_o);
    else n_pass++;
    req_hi = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ctrl_req_o) req_hi++;
    end
    n_total++;
    if (req_hi !== 0) $display("FAIL err_halt req_cycles=%0d want=0", req_hi);
    else n_pass++;
    auto_mode = 1'b1;
    redirect(32'h0000_0080);
    wait_ready(seen);
    n_total++;
    if (!seen || pc_o !== 32'h80 || instruction_o !== 32'hC0DE_0080)
      $display("FAIL err_resume rdy=%b pc=%h ins=%h want 1 80 c0de0080", seen, pc_o, instruction_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    bit seen;
    redirect(32'h0000_0700);
    auto_mode = 1'b0;
    wait_stb(seen);
    ack_man = 1'b1;
    dat_man = 32'hABCD_0000;
    step();
    step();
    step();
    ack_man = 1'b0;
    n_total++;
    if (!seen || {data_ready_o, stb_o} !== 2'b11 || pc_o !== 32'h700)
      $display("FAIL midbus_setup rdy=%b stb=%b pc=%h want 1 1 700", data_ready_o, stb_o, pc_o);
    else n_pass++;
    reset_ni = 1'b0;
    step();
    n_total++;
    if ({data_ready_o, ctrl_req_o, cyc_o, stb_o, fetch_err_o} !== 5'b0 ||
        {adr_o, err_pc_o, pc_o, instruction_o} !== 126'h0 || sel_o !== 4'b1111)
      $display("FAIL midbus_reset flags=%b adr=%h err_pc=%h pc=%h ins=%h sel=%b want all 0 sel 1111",
               {data_ready_o, ctrl_req_o, cyc_o, stb_o, fetch_err_o}, adr_o, err_pc_o, pc_o, instruction_o, sel_o);
    else n_pass++;
    reset_ni = 1'b1;
    auto_mode = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_discard();
    test_ack_redirect();
    test_bus_error();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
